// File: rtl/l2_resp_pkg.sv
// Shared types and helpers for the L2 burst responder.
// Burst wrapping is compiled in when L2_RESP_WRAP_EN is defined.
package l2_resp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StBurst
  } state_e;

  localparam int unsigned BEAT_BYTES  = 4;
  localparam int unsigned LATENCY_MIN = 2;
  localparam int unsigned LATENCY_MAX = 15;

  // A zero burst_size encodes the maximum burst of 32 beats.
  function automatic logic [5:0] burst_beats(input logic [4:0] size);
    return (size == 5'd0) ? 6'd32 : {1'b0, size};
  endfunction

  function automatic logic is_pow2(input logic [5:0] n);
    return (n != 6'd0) && ((n & (n - 6'd1)) == 6'd0);
  endfunction

endpackage

// File: rtl/l2_sram.sv
// Single-port synchronous word RAM: one read or one write per cycle, registered read data.
// Array contents are never reset; only the read register is.
module l2_sram #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read data only moves on a read, so it holds its last value between bursts.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/l2_burst_responder.sv
// Responder end of the L1-to-L2 burst protocol, backed by an internal word RAM.
// Define L2_RESP_WRAP_EN for critical-word-first wrapping on power-of-two bursts.
module l2_burst_responder
  import l2_resp_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rreq,
  input  logic        wreq,
  input  logic [31:0] addr,
  input  logic [4:0]  burst_size,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy
);

  localparam int unsigned ByteOff  = $clog2(BEAT_BYTES);
  localparam logic [3:0]  WaitLoad = 4'(LATENCY - LATENCY_MIN);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("l2_burst_responder: LATENCY out of range");
  end

  state_e            state_q;
  logic              is_read_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_nx;
  logic [5:0]        beats_q;
  logic [3:0]        wait_q;
  logic              busy_q;

  logic              ram_re;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;

  // Upper address bits alias and the byte offset is ignored.
  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_W+ByteOff], addr[ByteOff-1:0]};

`ifdef L2_RESP_WRAP_EN
  logic [5:0]        len_q;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    wrap_mask = '0;
    ptr_nx    = ptr_q + ADDR_W'(1);
    if (is_pow2(len_q)) begin
      wrap_mask = ADDR_W'(len_q - 6'd1);
      ptr_nx    = (ptr_q & ~wrap_mask) | (ptr_nx & wrap_mask);
    end
  end
`else
  always_comb begin
    ptr_nx = ptr_q + ADDR_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      is_read_q <= 1'b0;
      ptr_q     <= '0;
      beats_q   <= '0;
      wait_q    <= '0;
      busy_q    <= 1'b1;
`ifdef L2_RESP_WRAP_EN
      len_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rreq || wreq) begin
            is_read_q <= rreq;
            ptr_q     <= addr[ADDR_W+ByteOff-1:ByteOff];
            beats_q   <= burst_beats(burst_size);
            wait_q    <= WaitLoad;
            state_q   <= StWait;
`ifdef L2_RESP_WRAP_EN
            len_q     <= burst_beats(burst_size);
`endif
          end
        end
        StWait: begin
          if (wait_q == 4'd0) begin
            state_q <= StBurst;
            busy_q  <= 1'b0;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StBurst: begin
          ptr_q   <= ptr_nx;
          beats_q <= beats_q - 6'd1;
          if (beats_q == 6'd1) begin
            state_q <= StIdle;
            busy_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Reads run one word ahead so each beat finds its data already registered.
  always_comb begin
    ram_re   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = ptr_q;
    if (!reset) begin
      if (state_q == StWait && wait_q == 4'd0 && is_read_q) begin
        ram_re = 1'b1;
      end
      if (state_q == StBurst) begin
        if (!is_read_q) begin
          ram_we = 1'b1;
        end else if (beats_q != 6'd1) begin
          ram_re   = 1'b1;
          ram_addr = ptr_nx;
        end
      end
    end
  end

  l2_sram #(
    .ADDR_W(ADDR_W),
    .DATA_W(32)
  ) u_sram (
    .clk  (clk),
    .reset(reset),
    .re   (ram_re),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata),
    .rdata(rdata)
  );

  assign busy = busy_q;

endmodule

// File: tb/tb_l2_burst_responder.sv
// Bench for l2_burst_responder: two instances (default, and ADDR_W=4/LATENCY=5) share stimulus
// and are checked every cycle against a burst-level model; honours L2_RESP_WRAP_EN.
module tb_l2_burst_responder;

  localparam int NI   = 2;
  localparam int LAT0 = 2;
  localparam int LAT1 = 5;
  localparam int AW0  = 12;
  localparam int AW1  = 4;
  localparam int LAT [NI] = '{LAT0, LAT1};
  localparam int DEP [NI] = '{1 << AW0, 1 << AW1};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rreq = 1'b0;
  logic        wreq = 1'b0;
  logic [31:0] addr = '0;
  logic [4:0]  burst_size = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata0, rdata1;
  logic        busy0, busy1;

  int total = 0;
  int bad   = 0;

  l2_burst_responder #(.ADDR_W(AW0), .LATENCY(LAT0)) dut0 (
    .clk(clk), .reset(reset), .rreq(rreq), .wreq(wreq), .addr(addr),
    .burst_size(burst_size), .wdata(wdata), .rdata(rdata0), .busy(busy0)
  );

  l2_burst_responder #(.ADDR_W(AW1), .LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(reset), .rreq(rreq), .wreq(wreq), .addr(addr),
    .burst_size(burst_size), .wdata(wdata), .rdata(rdata1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: one burst record per instance plus a word-level memory image.
  logic [31:0] mem   [NI][4096];
  bit          known [NI][4096];
  int          b_start [NI];
  int          b_n     [NI];
  int          b_base  [NI];
  bit          b_rd    [NI];
  int          free_at [NI];
  logic [31:0] last    [NI];
  bit          last_ok [NI];
  int          cyc = 0;
  bit          chk_en = 1'b0;

  function automatic bit in_beat(input int i, input int c);
    return b_n[i] > 0 && c >= b_start[i] && c < b_start[i] + b_n[i];
  endfunction

  function automatic int word_of(input int i, input int k);
    int w;
    w = b_base[i] + k;
`ifdef L2_RESP_WRAP_EN
    if ((b_n[i] & (b_n[i] - 1)) == 0) begin
      w = (b_base[i] & ~(b_n[i] - 1)) | ((b_base[i] + k) & (b_n[i] - 1));
    end
`endif
    return w % DEP[i];
  endfunction

  initial begin : model
    int mw;
    for (int i = 0; i < NI; i++) begin
      b_n[i] = 0; free_at[i] = 0; last_ok[i] = 1'b0; last[i] = '0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        if (reset) begin
          b_n[i]     = 0;
          free_at[i] = cyc + 1;
          last[i]    = '0;
          last_ok[i] = 1'b1;
        end else begin
          if (in_beat(i, cyc)) begin
            mw = word_of(i, cyc - b_start[i]);
            if (b_rd[i]) begin
              last[i]    = mem[i][mw];
              last_ok[i] = known[i][mw];
            end else begin
              mem[i][mw]   = wdata;
              known[i][mw] = 1'b1;
            end
          end
          if (cyc >= free_at[i] && (rreq || wreq)) begin
            b_rd[i]    = rreq;
            b_base[i]  = int'(addr[31:2] % 30'(DEP[i]));
            b_n[i]     = (burst_size == 5'd0) ? 32 : int'(burst_size);
            b_start[i] = cyc + LAT[i];
            free_at[i] = b_start[i] + b_n[i];
          end
        end
      end
      if (reset) chk_en = 1'b1;
      cyc++;
    end
  end

  initial begin : compare
    logic [31:0] er, ar;
    logic        ab;
    bit          ok;
    int          cw;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < NI; i++) begin
          ab = (i == 0) ? busy0 : busy1;
          ar = (i == 0) ? rdata0 : rdata1;
          check($sformatf("model_busy%0d", i), {31'd0, ab}, {31'd0, !in_beat(i, cyc)});
          if (in_beat(i, cyc) && b_rd[i]) begin
            cw = word_of(i, cyc - b_start[i]);
            ok = known[i][cw];
            er = mem[i][cw];
          end else begin
            ok = last_ok[i];
            er = last[i];
          end
          if (ok) check($sformatf("model_rdata%0d", i), ar, er);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      wdata = $urandom;
    end
  endtask

  // Issue a burst at the current negedge (cycle 0) and pin one instance's beat window literally.
  task automatic burst(input int inst, input bit rd, input logic [31:0] a, input logic [4:0] sz,
                       input logic [31:0] dbase, input bit chk_rd, input logic [31:0] ex [32]);
    int n;
    int l;
    n = (sz == 5'd0) ? 32 : int'(sz);
    l = LAT[inst];
    rreq = rd; wreq = !rd; addr = a; burst_size = sz;
    for (int c = 1; c <= l + n; c++) begin
      @(negedge clk);
      rreq = 1'b0; wreq = 1'b0;
      if (c >= l && c < l + n) begin
        wdata = dbase + 32'(c - l);
        check($sformatf("lit_busy_low%0d_c%0d", inst, c), {31'd0, inst == 0 ? busy0 : busy1}, 0);
        if (chk_rd) check($sformatf("lit_rdata%0d_c%0d", inst, c),
                          inst == 0 ? rdata0 : rdata1, ex[c - l]);
      end else begin
        wdata = $urandom;
        check($sformatf("lit_busy_high%0d_c%0d", inst, c), {31'd0, inst == 0 ? busy0 : busy1}, 1);
      end
    end
  endtask

  initial begin : stim
    logic [31:0] ex [32];
    int r;
    for (int k = 0; k < 32; k++) ex[k] = '0;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("idle_busy0", {31'd0, busy0}, 1);
      check("idle_busy1", {31'd0, busy1}, 1);
      check("idle_rdata0", rdata0, 0);
      check("idle_rdata1", rdata1, 0);
    end

    // Write then read back 4 beats at byte 0x100 (words 0x40..0x43).
    burst(0, 1'b0, 32'h100, 5'd4, 32'hA0, 1'b0, ex);
    idle(15);
    for (int k = 0; k < 4; k++) ex[k] = 32'hA0 + 32'(k);
    burst(0, 1'b1, 32'h100, 5'd4, 32'h0, 1'b1, ex);
    idle(15);

    // Size 0 is 32 beats; the LATENCY=5 instance starts beating in cycle 5.
    burst(1, 1'b1, 32'h0, 5'd0, 32'h0, 1'b0, ex);
    idle(40);

    // Critical-word-first vs linear order from word 2 of an aligned 4-word block.
    burst(0, 1'b0, 32'h100, 5'd8, 32'hB0, 1'b0, ex);
    idle(15);
`ifdef L2_RESP_WRAP_EN
    ex[0] = 32'hB2; ex[1] = 32'hB3; ex[2] = 32'hB0; ex[3] = 32'hB1;
`else
    ex[0] = 32'hB2; ex[1] = 32'hB3; ex[2] = 32'hB4; ex[3] = 32'hB5;
`endif
    burst(0, 1'b1, 32'h108, 5'd4, 32'h0, 1'b1, ex);
    idle(15);

    // 16-word instance: a 2-beat burst from word 15 lands its second beat on word 0
    // (word 14 when wrapping within the aligned pair).
    burst(1, 1'b0, 32'h3C, 5'd2, 32'hC5, 1'b0, ex);
    idle(15);
    ex[0] = 32'hC5; ex[1] = 32'hC6;
    burst(1, 1'b1, 32'h3C, 5'd2, 32'h0, 1'b1, ex);
    idle(15);
    ex[0] = 32'hC6;
`ifdef L2_RESP_WRAP_EN
    burst(1, 1'b1, 32'h38, 5'd1, 32'h0, 1'b1, ex);
`else
    burst(1, 1'b1, 32'h00, 5'd1, 32'h0, 1'b1, ex);
`endif
    idle(15);

    // Reset during beat 2 of a write keeps beats 0 and 1 only.
    burst(0, 1'b0, 32'h0, 5'd4, 32'hE0, 1'b0, ex);
    idle(15);
    wreq = 1'b1; addr = 32'h0; burst_size = 5'd4;
    @(negedge clk); wreq = 1'b0;
    @(negedge clk); wdata = 32'hD0;
    @(negedge clk); wdata = 32'hD1;
    @(negedge clk); wdata = 32'hD2; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("rst_busy0", {31'd0, busy0}, 1);
    check("rst_rdata0", rdata0, 0);
    idle(15);
    ex[0] = 32'hD0; ex[1] = 32'hD1; ex[2] = 32'hE2; ex[3] = 32'hE3;
    burst(0, 1'b1, 32'h0, 5'd4, 32'h0, 1'b1, ex);
    idle(15);

    // Random traffic, including overlapping requests, aliased addresses and stray resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      wdata = $urandom;
      r = $urandom_range(0, 11);
      rreq = (r == 0) || (r == 2);
      wreq = (r == 1) || (r == 2);
      addr = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_00FF);
      burst_size = 5'($urandom);
      reset = ($urandom_range(0, 249) == 0);
    end
    @(negedge clk);
    rreq = 1'b0; wreq = 1'b0; reset = 1'b0;
    idle(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_burst_responder.md
# l2_burst_responder

Responder end of the L1-to-L2 burst protocol: accepts single-cycle read/write requests with a start address and burst length, then streams one 32-bit word per beat, signalling each beat by dropping `busy` low for one cycle. Backed by an internal single-port synchronous word RAM with a programmable first-beat latency. It sits below the L1 adapter as the L2/memory model for system bring-up and as the template for the real L2 slave.

## Interface
- `ADDR_W`, default 12: RAM word-index width; depth = 2^ADDR_W words.
- `LATENCY`, default 2, legal 2..15: cycles from the request cycle to the first beat.
- `clk` in 1: the single clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `rreq` in 1: read request pulse, one cycle.
- `wreq` in 1: write request pulse, one cycle.
- `addr` in 32: byte address of the first beat, sampled with the request.
- `burst_size` in 5: beat count, sampled with the request; 0 means 32 beats.
- `wdata` in 32: write beat data, sampled at the end of each write beat cycle.
- `rdata` out 32: read beat data, valid only in read beat cycles.
- `busy` out 1: low for exactly one cycle per beat, high at all other times.

## Operation
- States: IDLE, WAIT, BURST. The encoding is in the package.
- IDLE: `busy`=1. If `rreq|wreq` is sampled high, latch the direction (`rreq` wins when both are high), `addr[ADDR_W+1:2]` as the word pointer, and beats = `burst_size`, or 32 when it is 0. Load the wait counter with LATENCY-2 and go to WAIT.
- WAIT: count down. At 0 go to BURST. For reads, issue the RAM read of the first word so its data is ready in the first beat cycle.
- BURST: every cycle is a beat with `busy`=0.
  - Read beat: `rdata` = RAM[ptr]. The read for the next word is issued in the same cycle.
  - Write beat: RAM[ptr] <= `wdata` at the end of the cycle.
  - After each beat: ptr advances one word and beats decrements. When the last beat completes, go to IDLE.
- Pointer arithmetic: ptr is ADDR_W bits and wraps modulo 2^ADDR_W. Address bits above ADDR_W+1 alias. `addr[1:0]` is ignored.
- The beat counter is 6 bits so that it can hold 32.
- A request while not in IDLE violates the protocol and is ignored. It must not alter the burst in flight.
- Reset in any state: state=IDLE, `busy`=1, `rdata`=0, counters cleared. RAM contents are not cleared. A partially written burst keeps the beats already written.

## Timing
- Request sampled at the end of cycle 0. Beat k (k=0..N-1) occupies cycle LATENCY+k.
- `busy` reset value: 1. `rdata` reset value: 0. `rdata` holds its last value outside beats.
- The block returns to IDLE in the cycle after the last beat. A new request is accepted in that cycle, so back-to-back bursts are separated by LATENCY cycles of `busy`=1.
- No gaps inside a burst. The consumer must accept one beat per cycle.
- LATENCY=2 matches the adapter: request cycle, one adapter delay cycle, then the first beat.

## Configuration
- `L2_RESP_WRAP_EN` defined: when the beat count is a power of two (1, 2, 4, 8, 16, 32), ptr wraps within the burst-aligned block. Only the low log2(N) bits increment, which gives critical-word-first. Non-power-of-two counts increment linearly.
- `L2_RESP_WRAP_EN` undefined: always increments linearly.

## Structure
- Package `l2_resp_pkg` holds:
  - the state encoding;
  - `BEAT_BYTES`=4;
  - the `burst_beats(size)` function, which maps 0 to 32;
  - `LATENCY_MIN`=2.
- Sub-module `l2_sram`: single-port synchronous RAM, one read or one write per cycle, registered read data, ADDR_W-parameterised.

## Test plan
- Reset, then idle 5 cycles -> `busy`=1 and `rdata`=0 throughout. No RAM writes.
- `wreq` with `addr`=0x100, `burst_size`=4, `wdata`=0xA0..0xA3 on beats -> `busy` low in cycles 2..5. Words 0x40..0x43 are written. Then `rreq` for the same address returns 0xA0..0xA3 in cycles 2..5 of the read.
- `rreq` with `burst_size`=0 -> exactly 32 beats, then `busy`=1. LATENCY=5 puts the first beat in cycle 5.
- `rreq` with `addr`=0x108, `burst_size`=4:
  - with `L2_RESP_WRAP_EN`: words 2, 3, 0, 1 of the block;
  - without it: words 2, 3, 4, 5.
- Pointer wrap: ADDR_W=4, `addr`=0x3C, `burst_size`=2 without wrap -> reads words 15 then 0.
- `reset` asserted in the middle of a 4-beat write after beat 1 -> `busy`=1 on the next cycle. Words 0 and 1 are written, 2 and 3 are unchanged, and the next request is served normally.
